// File: rtl/mmio_bridge_if.sv
`default_nettype none
// ============================================================================
//  mmio_bridge_if
//  CPU-side request bus and IO-channel bus seen by the MMIO bridge.
//  Revision: 1.0
// ============================================================================
interface mmio_bridge_if #(
    parameter int N_CH = 4
) ();
    logic                   cpu_rd;
    logic                   cpu_wr;
    logic [31:0]            cpu_addr;
    logic [31:0]            cpu_wdata;
    logic [31:0]            cpu_rdata;
    logic                   cpu_stall;
    logic                   cpu_err;

    logic [N_CH-1:0]        io_sel;
    logic                   io_rd;
    logic                   io_wr;
    logic [31:0]            io_wdata;
    logic [32*N_CH-1:0]     io_rdata;
    logic [N_CH-1:0]        io_ready;

    // Bridge view: serves CPU requests and drives the IO channels.
    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall, cpu_err,
        output io_sel, io_rd, io_wr, io_wdata,
        input  io_rdata, io_ready
    );

    // Environment view: CPU stage plus the peripheral channels.
    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall, cpu_err,
        input  io_sel, io_rd, io_wr, io_wdata,
        output io_rdata, io_ready
    );
endinterface
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
//  mmio_bridge
//  Routes CPU loads/stores to data memory (zero stall) or to N_CH MMIO
//  channels through a registered request/ready handshake with timeout.
//  Revision: 1.0
// ============================================================================
module mmio_bridge #(
    parameter int          N_CH         = 4,
    parameter logic [31:0] IO_BASE      = 32'hFFFF_FC00,
    parameter int          CH_SPAN_LOG2 = 4,
    parameter int          TIMEOUT      = 255
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mmio_bridge_if.slave     bus,
    output logic             mem_rd,
    output logic             mem_wr,
    input  wire logic [31:0] mem_rdata
);

    localparam logic [32:0] c_win_size  = 33'(N_CH) << CH_SPAN_LOG2;
    localparam logic [31:0] c_span_mask = 32'((64'd1 << CH_SPAN_LOG2) - 64'd1);
    localparam logic [15:0] c_cnt_last  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IO_WAIT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_CH-1:0]    io_sel_q, io_sel_d;
    logic               io_rd_q, io_rd_d;
    logic               io_wr_q, io_wr_d;
    logic [31:0]        io_wdata_q, io_wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [32:0]        w_offset;
    logic               w_high;
    logic               w_mapped;
    logic [N_CH-1:0]    w_onehot;
    logic               w_ready;
    logic [31:0]        w_slice_masked [N_CH];
    logic [31:0]        w_sel_rdata;
    logic [31:0]        w_cpu_rdata;
    logic               w_cpu_stall;
    logic               w_cpu_err;

    // Everything at or above IO_BASE belongs to the IO side, mapped or not.
    assign w_offset = {1'b0, bus.cpu_addr} - {1'b0, IO_BASE};
    assign w_high   = (bus.cpu_addr >= IO_BASE);
    assign w_mapped = w_high && (w_offset < c_win_size)
                      && ((w_offset[31:0] & c_span_mask) == 32'd0);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign w_onehot[k]       = ((w_offset[31:0] >> CH_SPAN_LOG2) == 32'(k));
        assign w_slice_masked[k] = bus.io_rdata[32*k +: 32] & {32{io_sel_q[k]}};
    end

    // io_sel_q is one-hot, so OR-ing the masked slices selects one channel.
    always_comb begin
        w_sel_rdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sel_rdata = w_sel_rdata | w_slice_masked[k];
        end
    end

    assign w_ready = |(bus.io_ready & io_sel_q);

    always_comb begin
        state_d     = state_q;
        io_sel_d    = io_sel_q;
        io_rd_d     = io_rd_q;
        io_wr_d     = io_wr_q;
        io_wdata_d  = io_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        w_cpu_rdata = 32'd0;
        w_cpu_stall = 1'b0;
        w_cpu_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                err_d   = 1'b0;
                rdata_d = 32'd0;
                if (bus.cpu_rd || bus.cpu_wr) begin
                    if ((bus.cpu_rd && bus.cpu_wr) || (w_high && !w_mapped)) begin
                        w_cpu_stall = 1'b1;
                        err_d       = 1'b1;
                        state_d     = S_DONE;
                    end else if (w_high) begin
                        w_cpu_stall = 1'b1;
                        io_sel_d    = w_onehot;
                        io_rd_d     = bus.cpu_rd;
                        io_wr_d     = bus.cpu_wr;
                        io_wdata_d  = bus.cpu_wdata;
                        cnt_d       = 16'd0;
                        state_d     = S_IO_WAIT;
                    end else begin
                        mem_rd      = bus.cpu_rd;
                        mem_wr      = bus.cpu_wr;
                        w_cpu_rdata = bus.cpu_rd ? mem_rdata : 32'd0;
                    end
                end
            end

            S_IO_WAIT: begin
                w_cpu_stall = 1'b1;
                if (w_ready) begin
                    rdata_d  = io_rd_q ? w_sel_rdata : 32'd0;
                    err_d    = 1'b0;
                    io_sel_d = '0;
                    io_rd_d  = 1'b0;
                    io_wr_d  = 1'b0;
                    state_d  = S_DONE;
                end else if (cnt_q == c_cnt_last) begin
                    rdata_d  = 32'd0;
                    err_d    = 1'b1;
                    io_sel_d = '0;
                    io_rd_d  = 1'b0;
                    io_wr_d  = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_DONE: begin
                // CPU advances on this edge; the held request is not re-decoded.
                w_cpu_rdata = rdata_q;
                w_cpu_err   = err_q;
                err_d       = 1'b0;
                rdata_d     = 32'd0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            io_sel_q   <= '0;
            io_rd_q    <= 1'b0;
            io_wr_q    <= 1'b0;
            io_wdata_q <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            io_sel_q   <= io_sel_d;
            io_rd_q    <= io_rd_d;
            io_wr_q    <= io_wr_d;
            io_wdata_q <= io_wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.cpu_rdata = w_cpu_rdata;
    assign bus.cpu_stall = w_cpu_stall;
    assign bus.cpu_err   = w_cpu_err;
    assign bus.io_sel    = io_sel_q;
    assign bus.io_rd     = io_rd_q;
    assign bus.io_wr     = io_wr_q;
    assign bus.io_wdata  = io_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
//  tb_mmio_bridge
//  Transaction-level reference model with per-cycle output comparison.
//  Revision: 1.0
// ============================================================================
module tb_mmio_bridge;

    localparam int          N_CH = 4;
    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mmio_bridge_if #(.N_CH(N_CH)) bus ();

    mmio_bridge #(
        .N_CH(N_CH), .IO_BASE(BASE), .CH_SPAN_LOG2(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    // Expected outputs for the current cycle, set by the transaction model.
    bit          chk_en = 0;
    bit          e_stall, e_err, e_rd_chk, e_mem_rd, e_mem_wr, e_io_rd, e_io_wr;
    logic [31:0] e_rdata;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata = 32'd0;

    int          n_stall;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
            chk("cpu_err",   32'(bus.cpu_err),   32'(e_err));
            if (e_rd_chk) chk("cpu_rdata", bus.cpu_rdata, e_rdata);
            chk("mem_rd",    32'(mem_rd),        32'(e_mem_rd));
            chk("mem_wr",    32'(mem_wr),        32'(e_mem_wr));
            chk("io_sel",    32'(bus.io_sel),    32'(e_sel));
            chk("io_rd",     32'(bus.io_rd),     32'(e_io_rd));
            chk("io_wr",     32'(bus.io_wr),     32'(e_io_wr));
            chk("io_wdata",  bus.io_wdata,       e_wdata);
        end
    end

    task automatic expect_out(input bit st, input bit er, input bit rc, input logic [31:0] rd,
                              input bit mr, input bit mw, input logic [3:0] sel,
                              input bit ir, input bit iw);
        e_stall = st; e_err = er; e_rd_chk = rc; e_rdata = rd;
        e_mem_rd = mr; e_mem_wr = mw; e_sel = sel; e_io_rd = ir; e_io_wr = iw;
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.cpu_stall) n_stall++;
        else begin
            last_rdata = bus.cpu_rdata;
            last_err   = bus.cpu_err;
        end
        @(posedge clk);
        #1;
    endtask

    // One CPU access from issue to completion; rdy_at = IO_WAIT cycle index
    // at which the selected channel becomes ready (-1: never).
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rdy_at, input bit keep_data);
        bit          high, mapped, done, rdy;
        logic [31:0] off;
        int          ch;
        logic [3:0]  sel;
        n_stall = 0;
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        if (!keep_data) begin
            mem_rdata = $urandom;
            for (int k = 0; k < N_CH; k++) bus.io_rdata[k*32 +: 32] = $urandom;
        end
        bus.io_ready = 4'($urandom);
        high   = (addr >= BASE);
        off    = addr - BASE;
        mapped = high && (off < 32'd64) && (off[3:0] == 4'd0);
        ch     = int'(off >> 4);
        if (!rd && !wr) begin
            expect_out(0, 0, 1, 32'd0, 0, 0, 4'd0, 0, 0);
            tick();
        end else if ((rd && wr) || (high && !mapped)) begin
            expect_out(1, 0, 1, 32'd0, 0, 0, 4'd0, 0, 0);
            tick();
            expect_out(0, 1, 1, 32'd0, 0, 0, 4'd0, 0, 0);
            tick();
        end else if (!high) begin
            expect_out(0, 0, 1, rd ? mem_rdata : 32'd0, rd, wr, 4'd0, 0, 0);
            tick();
        end else begin
            expect_out(1, 0, 1, 32'd0, 0, 0, 4'd0, 0, 0);
            tick();
            e_wdata = wdata;
            sel     = 4'(1 << ch);
            done    = 0;
            for (int i = 0; i < TMO && !done; i++) begin
                rdy = (rdy_at >= 0) && (i >= rdy_at);
                bus.io_ready     = 4'($urandom);
                bus.io_ready[ch] = rdy;
                expect_out(1, 0, 0, 32'd0, 0, 0, sel, rd, wr);
                tick();
                if (rdy) done = 1;
            end
            expect_out(0, !done, 1, (done && rd) ? bus.io_rdata[ch*32 +: 32] : 32'd0,
                       0, 0, 4'd0, 0, 0);
            tick();
        end
    endtask

    initial begin
        int          kind, ch, pick;
        int          rdy_tab [5];
        logic [31:0] a;
        rdy_tab = '{0, 1, 2, TMO-1, -1};

        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.io_rdata = '0; bus.io_ready = '0; mem_rdata = 0;
        @(posedge clk); #1;
        expect_out(0, 0, 1, 32'd0, 0, 0, 4'd0, 0, 0);
        chk_en = 1;
        tick(); tick();
        rst_n = 1;
        tick();
        chk("reset_io_sel", 32'(bus.io_sel), 32'd0);
        chk("reset_io_wdata", bus.io_wdata, 32'd0);

        mem_rdata = 32'h1234_5678;
        do_txn(1, 0, 32'h0000_0040, 32'd0, 0, 1);
        chk("mem_load_rdata", last_rdata, 32'h1234_5678);
        chk("mem_load_stall", 32'(n_stall), 32'd0);

        bus.io_rdata = '0;
        bus.io_rdata[63:32] = 32'h0000_00A5;
        do_txn(1, 0, 32'hFFFF_FC10, 32'd0, 0, 1);
        chk("io_rd_ch1_stall", 32'(n_stall), 32'd2);
        chk("io_rd_ch1_rdata", last_rdata, 32'h0000_00A5);
        chk("io_rd_ch1_err", 32'(last_err), 32'd0);

        do_txn(0, 1, 32'hFFFF_FC20, 32'h0000_00FF, 2, 0);
        chk("io_wr_ch2_stall", 32'(n_stall), 32'd4);
        chk("io_wr_ch2_err", 32'(last_err), 32'd0);

        do_txn(1, 0, 32'hFFFF_FC00, 32'd0, -1, 0);
        chk("timeout_stall", 32'(n_stall), 32'd9);
        chk("timeout_err", 32'(last_err), 32'd1);
        chk("timeout_rdata", last_rdata, 32'd0);

        do_txn(1, 0, 32'hFFFF_FC44, 32'd0, 0, 0);
        chk("unmapped_stall", 32'(n_stall), 32'd1);
        chk("unmapped_err", 32'(last_err), 32'd1);

        do_txn(1, 1, 32'h0000_0100, 32'd7, 0, 0);
        chk("both_stall", 32'(n_stall), 32'd1);
        chk("both_err", 32'(last_err), 32'd1);

        do_txn(0, 1, 32'hFFFF_FFF0, 32'd3, 0, 0);
        chk("beyond_err", 32'(last_err), 32'd1);

        // Reset while the IO access is waiting on channel 3.
        bus.cpu_rd = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'hFFFF_FC30; bus.cpu_wdata = 32'hDEAD_0001;
        bus.io_ready = '0;
        expect_out(1, 0, 1, 32'd0, 0, 0, 4'd0, 0, 0);
        tick();
        e_wdata = 32'hDEAD_0001;
        expect_out(1, 0, 0, 32'd0, 0, 0, 4'b1000, 1, 0);
        tick(); tick();
        rst_n = 0; bus.cpu_rd = 0; e_wdata = 32'd0;
        expect_out(0, 0, 1, 32'd0, 0, 0, 4'd0, 0, 0);
        tick();
        rst_n = 1;
        do_txn(1, 0, 32'h0000_2000, 32'd0, 0, 0);
        chk("post_reset_mem_stall", 32'(n_stall), 32'd0);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            ch   = $urandom_range(0, N_CH-1);
            pick = $urandom_range(0, 4);
            case (kind)
                0: do_txn(0, 0, $urandom, $urandom, 0, 0);
                1, 2: begin
                    a = $urandom & 32'h7FFF_FFFF;
                    if (kind == 1) do_txn(1, 0, a, $urandom, 0, 0);
                    else           do_txn(0, 1, a, $urandom, 0, 0);
                end
                3, 4, 5: begin
                    a = BASE + 32'(ch << 4);
                    if ($urandom_range(0, 1) == 1) do_txn(1, 0, a, $urandom, rdy_tab[pick], 0);
                    else                           do_txn(0, 1, a, $urandom, rdy_tab[pick], 0);
                end
                6: do_txn(1, 0, BASE + 32'(ch << 4) + $urandom_range(1, 15), $urandom, 0, 0);
                7: do_txn(0, 1, BASE + 32'd64 + $urandom_range(0, 32'h3BF), $urandom, 0, 0);
                8: do_txn(1, 1, $urandom, $urandom, 0, 0);
                default: do_txn(1, 0, BASE - 32'd1 - $urandom_range(0, 15), $urandom, 0, 0);
            endcase
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Parametrised successor to the single-cycle memory/IO address decoder.
- Sits between the CPU load/store stage and data memory plus N_CH memory-mapped peripheral channels (LED, switch, keypad, seg, button, ...).
- Memory accesses pass through with zero stall.
- IO accesses go through a registered request/ready handshake with CPU stall, unmapped-address error and timeout detection.

Parameters:
- N_CH, 4, number of IO channels (1..16).
- IO_BASE, 32'hFFFF_FC00, base of IO window; window size is N_CH<<CH_SPAN_LOG2 bytes.
- CH_SPAN_LOG2, 4, log2 bytes per channel; only offset 0 of each span is mapped.
- TIMEOUT, 255, maximum IO_WAIT cycles before an error completion (1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_rd  in  1  CPU load request, held by CPU while cpu_stall=1.
- cpu_wr  in  1  CPU store request, held by CPU while cpu_stall=1.
- cpu_addr  in  32  byte address from ALU.
- cpu_wdata  in  32  store data from register file.
- cpu_rdata  out  32  load data to writeback.
- cpu_stall  out  1  CPU must hold the request and not advance.
- cpu_err  out  1  one-cycle bus-error pulse on the completing cycle.
- mem_rd  out  1  data memory read enable.
- mem_wr  out  1  data memory write enable.
- mem_rdata  in  32  data memory read data.
- io_sel  out  N_CH  one-hot channel select, registered.
- io_rd  out  1  IO read strobe, registered.
- io_wr  out  1  IO write strobe, registered.
- io_wdata  out  32  IO write data, registered.
- io_rdata  in  32*N_CH  flattened channel read data; channel k is bits [32k+31:32k].
- io_ready  in  N_CH  per-channel ready/acknowledge.

Behaviour:
- Decode:
  - is_io = cpu_addr in [IO_BASE, IO_BASE + (N_CH<<CH_SPAN_LOG2)).
  - ch = (cpu_addr - IO_BASE) >> CH_SPAN_LOG2.
  - Any address in IO window with nonzero low CH_SPAN_LOG2 bits is unmapped.
  - An address from IO_BASE up to 32'hFFFF_FFFF, beyond the window, is unmapped; it is never routed to memory.
- Memory path (state IDLE, address not IO-range):
  - mem_rd = cpu_rd, mem_wr = cpu_wr, cpu_rdata = mem_rdata, cpu_stall = 0. Purely combinational.
- FSM states: IDLE, IO_WAIT, DONE.
- IDLE:
  - IO-range request with cpu_rd^cpu_wr and a mapped address: cpu_stall=1.
  - Next edge latches io_sel = onehot(ch), io_rd/io_wr, io_wdata = cpu_wdata, clears the timeout counter, then goes to IO_WAIT.
  - IO-range request that is unmapped, or any request with cpu_rd & cpu_wr both high: cpu_stall=1; next state DONE with err_q=1, rdata_q=0. No memory or IO strobe is issued.
- IO_WAIT:
  - cpu_stall=1. io_sel/io_rd/io_wr are held.
  - If io_ready[ch] is high: capture rdata_q = io_rdata slice (0 for writes), go to DONE, clear strobes and io_sel.
  - Else if counter == TIMEOUT-1: go to DONE with err_q=1, rdata_q=0, clear strobes.
  - Otherwise increment counter. Ready bits of unselected channels are ignored.
- DONE:
  - cpu_stall=0, cpu_rdata=rdata_q, cpu_err=err_q.
  - Next state is always IDLE; err_q is cleared there.
  - The CPU advances on this edge, so the request is never reissued.
- Latency:
  - IO access with ready already high: 2 stall cycles, result on cycle 3.
  - Timeout: TIMEOUT+1 stall cycles.
  - Unmapped access: 1 stall cycle.
- Reset (asynchronous, any state):
  - State IDLE; io_sel=0, io_rd=0, io_wr=0, io_wdata=0, rdata_q=0, err_q=0, counter=0.
  - Combinational outputs follow IDLE rules. An in-flight IO access is abandoned with no completion.
- cpu_rdata is 0 in IDLE whenever no memory read is active.

Test Plan:
- Memory load: addr 0x0000_0040, cpu_rd=1, mem_rdata=0x1234_5678 -> same cycle cpu_rdata=0x1234_5678, mem_rd=1, cpu_stall=0, io_sel=0.
- IO read on channel 1: addr 0xFFFF_FC10, io_ready[1] tied high, io_rdata[63:32]=0x0000_00A5 -> stall on cycles 0-1, io_sel=4'b0010 with io_rd on cycle 1, cycle 2 cpu_rdata=0xA5 with stall=0 and err=0.
- IO write on channel 2 with 3-cycle ready delay: addr 0xFFFF_FC20, wdata 0xFF -> io_wr and io_wdata=0xFF held until io_ready[2]; stall lasts 4 cycles; io_sel=0 in DONE.
- Timeout: TIMEOUT=8, channel 0 never ready -> 9 stall cycles, then cpu_err=1 for one cycle, cpu_rdata=0, FSM returns to IDLE.
- Unmapped and both-strobe errors:
  - addr 0xFFFF_FC44: one stall cycle, then cpu_err pulse, no io or mem strobe.
  - cpu_rd=cpu_wr=1 on any address: same response.
- Reset mid-access: rst_n low during IO_WAIT -> outputs clear immediately; after release, a new memory access completes with zero stall.
